// File: rtl/stack_pkg.sv
// Shared op encoding, default width and stack-pointer sizing helper for the LIFO engine.
package stack_pkg;

  localparam int STACK_DATA_W = 8;

  typedef enum logic [1:0] {OP_IDLE, OP_PUSH, OP_POP, OP_REPL} stack_op_t;

  // Pointer must represent every count from 0 up to and including depth.
  function automatic int sp_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stack_mem.sv
// DEPTH x DATA_W register file: one synchronous write port, one asynchronous read port, no reset.
module stack_mem
  import stack_pkg::*;
#(
  parameter int DATA_W = STACK_DATA_W,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Address guard matters only when DEPTH is not a power of two.
  always_ff @(posedge clk) begin
    if (i_we && (int'(i_waddr) < DEPTH)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = (int'(i_raddr) < DEPTH) ? r_mem[i_raddr] : '0;

endmodule

// File: rtl/stack_engine.sv
// LIFO data/return-address stack with registered pop result and full/empty/error status.
// Optional macro STACK_STICKY_ERR_EN makes overflow/underflow sticky and adds the clr_err port.
module stack_engine
  import stack_pkg::*;
#(
  parameter  int DATA_W = STACK_DATA_W,
  parameter  int DEPTH  = 16,
  localparam int SP_W   = sp_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
`ifdef STACK_STICKY_ERR_EN
  input  logic              clr_err,
`endif
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic [SP_W-1:0]   sp,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [SP_W-1:0]   r_sp;
  logic [DATA_W-1:0] r_pop_data;
  logic              r_pop_valid;
  logic              r_ovf;
  logic              r_udf;

  stack_op_t         w_op;
  logic [SP_W-1:0]   w_sp_m1;
  logic [SP_W-1:0]   w_sp_nxt;
  logic [DATA_W-1:0] w_pd_nxt;
  logic              w_pv_nxt;
  logic              w_ovf_evt;
  logic              w_udf_evt;
  logic              w_we;
  logic [AW-1:0]     w_waddr;
  logic [DATA_W-1:0] w_rdata;

  assign w_sp_m1 = r_sp - SP_W'(1);
  assign full    = (r_sp == SP_W'(DEPTH));
  assign empty   = (r_sp == '0);

  stack_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (push_data),
    .i_raddr (w_sp_m1[AW-1:0]),
    .o_rdata (w_rdata)
  );

  always_comb begin
    case ({push, pop})
      2'b10:   w_op = OP_PUSH;
      2'b01:   w_op = OP_POP;
      2'b11:   w_op = OP_REPL;
      default: w_op = OP_IDLE;
    endcase
  end

  // Replace-top reads the old top through the async port before the same-edge write lands.
  always_comb begin
    w_sp_nxt  = r_sp;
    w_pd_nxt  = r_pop_data;
    w_pv_nxt  = 1'b0;
    w_ovf_evt = 1'b0;
    w_udf_evt = 1'b0;
    w_we      = 1'b0;
    w_waddr   = r_sp[AW-1:0];
    case (w_op)
      OP_PUSH: begin
        if (!full) begin
          w_we     = 1'b1;
          w_sp_nxt = r_sp + SP_W'(1);
        end else begin
          w_ovf_evt = 1'b1;
        end
      end
      OP_POP: begin
        if (!empty) begin
          w_pd_nxt = w_rdata;
          w_pv_nxt = 1'b1;
          w_sp_nxt = w_sp_m1;
        end else begin
          w_udf_evt = 1'b1;
        end
      end
      OP_REPL: begin
        w_pv_nxt = 1'b1;
        if (!empty) begin
          w_pd_nxt = w_rdata;
          w_we     = 1'b1;
          w_waddr  = w_sp_m1[AW-1:0];
        end else begin
          w_pd_nxt = push_data;
        end
      end
      default: begin
        w_pv_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sp        <= '0;
      r_pop_data  <= '0;
      r_pop_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
    end else begin
      r_sp        <= w_sp_nxt;
      r_pop_data  <= w_pd_nxt;
      r_pop_valid <= w_pv_nxt;
`ifdef STACK_STICKY_ERR_EN
      r_ovf       <= w_ovf_evt | (r_ovf & ~clr_err);
      r_udf       <= w_udf_evt | (r_udf & ~clr_err);
`else
      r_ovf       <= w_ovf_evt;
      r_udf       <= w_udf_evt;
`endif
    end
  end

  assign sp        = r_sp;
  assign pop_data  = r_pop_data;
  assign pop_valid = r_pop_valid;
  assign overflow  = r_ovf;
  assign underflow = r_udf;

endmodule

// File: tb/tb_stack_engine.sv
// Self-checking bench for stack_engine: queue-based reference model, directed scenarios, random traffic.
module tb_stack_engine;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int SPW   = $clog2(DEPTH + 1);

  logic           clk;
  logic           rst;
  logic           push;
  logic           pop;
  logic [DW-1:0]  push_data;
`ifdef STACK_STICKY_ERR_EN
  logic           clr_err;
`endif
  logic [DW-1:0]  pop_data;
  logic           pop_valid;
  logic [SPW-1:0] sp;
  logic           full;
  logic           empty;
  logic           overflow;
  logic           underflow;

  int checks   = 0;
  int failures = 0;

  stack_engine #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
`ifdef STACK_STICKY_ERR_EN
    .clr_err   (clr_err),
`endif
    .pop_data  (pop_data),
    .pop_valid (pop_valid),
    .sp        (sp),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue holds the stack contents, top at the back.
  logic [DW-1:0] stk[$];
  logic [DW-1:0] m_pd;
  logic          m_pv;
  logic          m_ovf;
  logic          m_udf;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      stk.delete();
      m_pd  <= '0;
      m_pv  <= 1'b0;
      m_ovf <= 1'b0;
      m_udf <= 1'b0;
    end else begin
      logic oe, ue;
      oe = 1'b0;
      ue = 1'b0;
      m_pv <= 1'b0;
      if (push && pop) begin
        m_pv <= 1'b1;
        if (stk.size() == 0) begin
          m_pd <= push_data;
        end else begin
          m_pd <= stk.pop_back();
          stk.push_back(push_data);
        end
      end else if (push) begin
        if (stk.size() < DEPTH) stk.push_back(push_data);
        else oe = 1'b1;
      end else if (pop) begin
        if (stk.size() > 0) begin
          m_pd <= stk.pop_back();
          m_pv <= 1'b1;
        end else begin
          ue = 1'b1;
        end
      end
`ifdef STACK_STICKY_ERR_EN
      m_ovf <= oe | (m_ovf & ~clr_err);
      m_udf <= ue | (m_udf & ~clr_err);
`else
      m_ovf <= oe;
      m_udf <= ue;
`endif
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("m_sp",        32'(sp),        32'(stk.size()));
    chk("m_full",      32'(full),      32'(stk.size() == DEPTH));
    chk("m_empty",     32'(empty),     32'(stk.size() == 0));
    chk("m_pop_data",  32'(pop_data),  32'(m_pd));
    chk("m_pop_valid", 32'(pop_valid), 32'(m_pv));
    chk("m_overflow",  32'(overflow),  32'(m_ovf));
    chk("m_underflow", 32'(underflow), 32'(m_udf));
  end

  task automatic op(input logic pu, input logic po, input logic [DW-1:0] d);
    push      = pu;
    pop       = po;
    push_data = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    push      = 1'b0;
    pop       = 1'b0;
    push_data = 8'h00;
`ifdef STACK_STICKY_ERR_EN
    clr_err   = 1'b0;
`endif
    #1;
    // T1: reset held while a push is requested
    rst       = 1'b0;
    push      = 1'b1;
    push_data = 8'h5A;
    repeat (3) @(posedge clk);
    #1;
    chk("t1_sp",        32'(sp),        32'd0);
    chk("t1_empty",     32'(empty),     32'd1);
    chk("t1_pop_data",  32'(pop_data),  32'h00);
    chk("t1_pop_valid", 32'(pop_valid), 32'd0);
    push = 1'b0;
    rst  = 1'b1;
    op(1'b0, 1'b0, 8'h00);
    chk("t1_sp_after", 32'(sp), 32'd0);

    // T2: LIFO order
    op(1'b1, 1'b0, 8'h11);
    op(1'b1, 1'b0, 8'h22);
    op(1'b1, 1'b0, 8'h33);
    chk("t2_sp3", 32'(sp), 32'd3);
    op(1'b0, 1'b1, 8'h00);
    chk("t2_pop0", 32'(pop_data), 32'h33);
    chk("t2_pv0",  32'(pop_valid), 32'd1);
    op(1'b0, 1'b1, 8'h00);
    chk("t2_pop1", 32'(pop_data), 32'h22);
    op(1'b0, 1'b1, 8'h00);
    chk("t2_pop2", 32'(pop_data), 32'h11);
    chk("t2_empty", 32'(empty), 32'd1);
    op(1'b0, 1'b0, 8'h00);
    chk("t2_pv_idle", 32'(pop_valid), 32'd0);

    // T3: fill to DEPTH, then overflow
    for (int i = 0; i < DEPTH; i++) op(1'b1, 1'b0, 8'(i));
    chk("t3_full", 32'(full), 32'd1);
    op(1'b1, 1'b0, 8'hAA);
    chk("t3_ovf", 32'(overflow), 32'd1);
    chk("t3_sp",  32'(sp), 32'd16);
    op(1'b0, 1'b1, 8'h00);
    chk("t3_pop", 32'(pop_data), 32'h0F);
`ifndef STACK_STICKY_ERR_EN
    chk("t3_ovf_pulse", 32'(overflow), 32'd0);
`endif
    repeat (DEPTH - 1) op(1'b0, 1'b1, 8'h00);
    chk("t3_drained", 32'(empty), 32'd1);

    // T5: replace-top and empty bypass
    op(1'b1, 1'b0, 8'h11);
    op(1'b1, 1'b0, 8'h22);
    op(1'b1, 1'b1, 8'h55);
    chk("t5_repl_pd", 32'(pop_data), 32'h22);
    chk("t5_repl_sp", 32'(sp), 32'd2);
    op(1'b0, 1'b1, 8'h00);
    chk("t5_new_top", 32'(pop_data), 32'h55);
    op(1'b0, 1'b1, 8'h00);
    op(1'b1, 1'b1, 8'h77);
    chk("t5_byp_pd", 32'(pop_data), 32'h77);
    chk("t5_byp_pv", 32'(pop_valid), 32'd1);
    chk("t5_byp_sp", 32'(sp), 32'd0);

    // T4: underflow leaves pop_data alone
    op(1'b0, 1'b1, 8'h00);
    chk("t4_udf", 32'(underflow), 32'd1);
    chk("t4_pv",  32'(pop_valid), 32'd0);
    chk("t4_pd",  32'(pop_data), 32'h77);
    chk("t4_sp",  32'(sp), 32'd0);
`ifdef STACK_STICKY_ERR_EN
    // T6: sticky flags persist until cleared
    repeat (5) op(1'b0, 1'b0, 8'h00);
    chk("t6_sticky", 32'(underflow), 32'd1);
    clr_err = 1'b1;
    op(1'b0, 1'b0, 8'h00);
    clr_err = 1'b0;
    chk("t6_cleared", 32'(underflow), 32'd0);
`else
    op(1'b0, 1'b0, 8'h00);
    chk("t4_udf_pulse", 32'(underflow), 32'd0);
`endif

    // Random traffic with shifting push/pop bias and occasional resets
    for (int n = 0; n < 3000; n++) begin
      int pb;
      int qb;
      pb = ((n / 300) % 2 == 0) ? 70 : 30;
      qb = 100 - pb;
      if ($urandom_range(299) == 0) begin
        rst = 1'b0;
        #2;
        rst = 1'b1;
      end
`ifdef STACK_STICKY_ERR_EN
      clr_err = ($urandom_range(19) == 0);
`endif
      op(($urandom_range(99) < pb), ($urandom_range(99) < qb), 8'($urandom));
    end

    op(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
